// File: rtl/alu_pkg.sv
// Shared select codes, FSM encoding and select-code helpers for the
// alu_operand_stage slice.
package alu_pkg;

  localparam logic       LHS_RS    = 1'b0;
  localparam logic       LHS_RT    = 1'b1;

  localparam logic [1:0] RHS_RS    = 2'b00;
  localparam logic [1:0] RHS_RT    = 2'b01;
  localparam logic [1:0] RHS_SHAMT = 2'b10;
  localparam logic [1:0] RHS_IMM   = 2'b11;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_STALL = 1'b1
  } state_e;

  function automatic logic lhs_sel(input logic shift_op);
    return shift_op ? LHS_RT : LHS_RS;
  endfunction

  function automatic logic [1:0] rhs_sel(input logic shift_op, input logic imm_op);
    logic [1:0] sel;
    case ({shift_op, imm_op})
      2'b10:   sel = RHS_RS;
      2'b11:   sel = RHS_SHAMT;
      2'b01:   sel = RHS_IMM;
      default: sel = RHS_RT;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/alu_operand_stage_fwd_mux.sv
// Single-source forward selector: EX result beats MEM result beats the
// register file; register 0 is never forwarded.
module fwd_mux #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] src_addr,
  input  logic [DATA_W-1:0]     rf_data,
  input  logic                  ex_wr_valid,
  input  logic                  ex_is_load,
  input  logic [REG_ADDR_W-1:0] ex_wr_addr,
  input  logic [DATA_W-1:0]     ex_wr_data,
  input  logic                  mem_wr_valid,
  input  logic [REG_ADDR_W-1:0] mem_wr_addr,
  input  logic [DATA_W-1:0]     mem_wr_data,
  output logic [DATA_W-1:0]     fwd_data,
  output logic                  fwd_hit
);

  logic nonzero;
  logic ex_hit;
  logic mem_hit;

  // A load in EX has no data yet, so it falls through to MEM/RF here;
  // the stage stalls on it separately when the source is actually used.
  assign nonzero = (src_addr != '0);
  assign ex_hit  = nonzero && ex_wr_valid && !ex_is_load && (ex_wr_addr == src_addr);
  assign mem_hit = nonzero && mem_wr_valid && (mem_wr_addr == src_addr);

  always_comb begin
    fwd_data = rf_data;
    if (ex_hit) begin
      fwd_data = ex_wr_data;
    end else if (mem_hit) begin
      fwd_data = mem_wr_data;
    end
  end

  assign fwd_hit = ex_hit || mem_hit;

endmodule

// File: rtl/alu_operand_stage.sv
// Registered ID/EX operand stage: select codes, operand muxing, EX/MEM
// forwarding, load-use stall and a valid/ready output register.
// Optional statistics counters are enabled by defining ALU_OPSTAGE_STATS_EN.
module alu_operand_stage
  import alu_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int IMM_W      = 16,
  parameter int SHAMT_W    = 5,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  i_valid,
  output logic                  o_in_ready,
  input  logic                  i_imm_op,
  input  logic                  i_shift_op,
  input  logic                  i_imm_signed,
  input  logic [REG_ADDR_W-1:0] i_rs_addr,
  input  logic [REG_ADDR_W-1:0] i_rt_addr,
  input  logic [DATA_W-1:0]     i_rs_data,
  input  logic [DATA_W-1:0]     i_rt_data,
  input  logic [IMM_W-1:0]      i_imm,
  input  logic [SHAMT_W-1:0]    i_shamt,
  input  logic                  i_ex_wr_valid,
  input  logic                  i_ex_is_load,
  input  logic [REG_ADDR_W-1:0] i_ex_wr_addr,
  input  logic [DATA_W-1:0]     i_ex_wr_data,
  input  logic                  i_mem_wr_valid,
  input  logic [REG_ADDR_W-1:0] i_mem_wr_addr,
  input  logic [DATA_W-1:0]     i_mem_wr_data,
  output logic                  o_valid,
  input  logic                  i_out_ready,
  output logic [DATA_W-1:0]     o_lhs,
  output logic [DATA_W-1:0]     o_rhs,
  output logic                  o_lhs_ctrl,
  output logic [1:0]            o_rhs_ctrl,
  output logic                  o_stall,
  output state_e                o_state
`ifdef ALU_OPSTAGE_STATS_EN
  ,
  output logic [15:0]           o_stall_cnt,
  output logic [15:0]           o_fwd_cnt
`endif
);

  state_e            state_q, state_d;
  logic              rs_used, rt_used;
  logic              rs_hazard, rt_hazard, hazard;
  logic              accept;
  logic              lhs_ctrl_d;
  logic [1:0]        rhs_ctrl_d;
  logic [DATA_W-1:0] rs_val, rt_val;
  logic              rs_fwd, rt_fwd;
  logic [DATA_W-1:0] imm_ext;
  logic [DATA_W-1:0] lhs_d, rhs_d;

  assign rs_used = !(i_shift_op && i_imm_op);
  assign rt_used = !(!i_shift_op && i_imm_op);

  assign rs_hazard = rs_used && (i_rs_addr != '0) && (i_rs_addr == i_ex_wr_addr);
  assign rt_hazard = rt_used && (i_rt_addr != '0) && (i_rt_addr == i_ex_wr_addr);
  assign hazard    = i_valid && i_ex_wr_valid && i_ex_is_load && (rs_hazard || rt_hazard);

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high; o_valid never drops and o_* never change until that transfer.
  assign o_in_ready = !hazard && (!o_valid || i_out_ready);
  assign accept     = i_valid && o_in_ready;
  assign o_stall    = hazard;
  assign o_state    = state_q;

  fwd_mux #(.DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W)) u_fwd_rs (
    .src_addr    (i_rs_addr),
    .rf_data     (i_rs_data),
    .ex_wr_valid (i_ex_wr_valid),
    .ex_is_load  (i_ex_is_load),
    .ex_wr_addr  (i_ex_wr_addr),
    .ex_wr_data  (i_ex_wr_data),
    .mem_wr_valid(i_mem_wr_valid),
    .mem_wr_addr (i_mem_wr_addr),
    .mem_wr_data (i_mem_wr_data),
    .fwd_data    (rs_val),
    .fwd_hit     (rs_fwd)
  );

  fwd_mux #(.DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W)) u_fwd_rt (
    .src_addr    (i_rt_addr),
    .rf_data     (i_rt_data),
    .ex_wr_valid (i_ex_wr_valid),
    .ex_is_load  (i_ex_is_load),
    .ex_wr_addr  (i_ex_wr_addr),
    .ex_wr_data  (i_ex_wr_data),
    .mem_wr_valid(i_mem_wr_valid),
    .mem_wr_addr (i_mem_wr_addr),
    .mem_wr_data (i_mem_wr_data),
    .fwd_data    (rt_val),
    .fwd_hit     (rt_fwd)
  );

  assign lhs_ctrl_d = lhs_sel(i_shift_op);
  assign rhs_ctrl_d = rhs_sel(i_shift_op, i_imm_op);
  assign imm_ext    = i_imm_signed ? DATA_W'($signed(i_imm)) : DATA_W'(i_imm);

  always_comb begin
    lhs_d = (lhs_ctrl_d == LHS_RT) ? rt_val : rs_val;
    rhs_d = rt_val;
    case (rhs_ctrl_d)
      RHS_RS:    rhs_d = rs_val;
      RHS_RT:    rhs_d = rt_val;
      RHS_SHAMT: rhs_d = DATA_W'(i_shamt);
      RHS_IMM:   rhs_d = imm_ext;
      default:   rhs_d = rt_val;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:   if (hazard)  state_d = ST_STALL;
      ST_STALL: if (!hazard) state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      o_valid    <= 1'b0;
      o_lhs      <= '0;
      o_rhs      <= '0;
      o_lhs_ctrl <= LHS_RS;
      o_rhs_ctrl <= RHS_RT;
    end else if (accept) begin
      o_valid    <= 1'b1;
      o_lhs      <= lhs_d;
      o_rhs      <= rhs_d;
      o_lhs_ctrl <= lhs_ctrl_d;
      o_rhs_ctrl <= rhs_ctrl_d;
    end else if (i_out_ready) begin
      o_valid    <= 1'b0;
    end
  end

`ifdef ALU_OPSTAGE_STATS_EN
  logic fwd_any;
  assign fwd_any = (rs_used && rs_fwd) || (rt_used && rt_fwd);

  always_ff @(posedge clock) begin
    if (reset) begin
      o_stall_cnt <= '0;
      o_fwd_cnt   <= '0;
    end else begin
      if (o_stall && (o_stall_cnt != 16'hFFFF)) o_stall_cnt <= o_stall_cnt + 16'd1;
      if (accept && fwd_any && (o_fwd_cnt != 16'hFFFF)) o_fwd_cnt <= o_fwd_cnt + 16'd1;
    end
  end
`else
  logic unused_fwd;
  assign unused_fwd = rs_fwd ^ rt_fwd;
`endif

endmodule

// File: doc/alu_operand_stage.md
Name: alu_operand_stage

Overview:
Registered ID/EX operand stage for the pd-series MIPS core. It succeeds the combinational operand-select controller: it generates the same lhs/rhs select codes, and also muxes the actual operand data. Adds EX/MEM forwarding, load-use stall detection and a valid/ready output register. It is parametrised in data, immediate, shift-amount and register-address width.

Parameters:
DATA_W, 32, operand/result width
IMM_W, 16, immediate field width (IMM_W <= DATA_W)
SHAMT_W, 5, shift-amount field width
REG_ADDR_W, 5, register index width

Ports:
clock  in  1  single clock, all state on rising edge
reset  in  1  synchronous, active-high
i_valid  in  1  decode stage presents an instruction
o_in_ready  out  1  stage can accept (combinational)
i_imm_op, i_shift_op, i_imm_signed  in  1 each  decoded op class; sign- vs zero-extend imm
i_rs_addr, i_rt_addr  in  REG_ADDR_W  source indices
i_rs_data, i_rt_data  in  DATA_W  register-file read data
i_imm  in  IMM_W  immediate field
i_shamt  in  SHAMT_W  shift amount
i_ex_wr_valid, i_ex_is_load  in  1 each  EX-stage writeback pending; EX op is a load
i_ex_wr_addr  in  REG_ADDR_W  EX destination
i_ex_wr_data  in  DATA_W  EX result (don't-care when load)
i_mem_wr_valid  in  1  MEM-stage writeback pending
i_mem_wr_addr  in  REG_ADDR_W  MEM destination
i_mem_wr_data  in  DATA_W  MEM result
o_valid  out  1  operands valid to ALU
i_out_ready  in  1  ALU/EX accepts
o_lhs, o_rhs  out  DATA_W  selected operands
o_lhs_ctrl  out  1  registered select code
o_rhs_ctrl  out  2  registered select code
o_stall  out  1  load-use stall asserted this cycle

Behaviour:
- Reset: o_valid=0, o_lhs=0, o_rhs=0, o_lhs_ctrl=0, o_rhs_ctrl=2'b01, state=RUN, o_stall=0.
- Select codes:
  - shift & !imm: lhs_ctrl=1, rhs=00.
  - shift & imm: lhs_ctrl=1, rhs=10.
  - !shift & imm: lhs_ctrl=0, rhs=11.
  - else: lhs_ctrl=0, rhs=01.
- Data mapping:
  - lhs_ctrl 0 -> rs; lhs_ctrl 1 -> rt.
  - rhs 00 -> rs; 01 -> rt; 10 -> zero-extended shamt; 11 -> imm, sign- or zero-extended per i_imm_signed.
- Source usage:
  - rs is used unless (shift & imm).
  - rt is used unless (!shift & imm).
- Forwarding, per used source, in priority order:
  - Address 0 is never forwarded and always reads i_*_data.
  - EX match (i_ex_wr_valid, not load) -> i_ex_wr_data.
  - Else MEM match -> i_mem_wr_data.
  - Else register-file data.
- Load-use hazard: i_valid & used source == i_ex_wr_addr & i_ex_wr_valid & i_ex_is_load & addr != 0.
- FSM:
  - RUN -> STALL on hazard.
  - STALL stays while the hazard persists; STALL -> RUN when it clears.
  - o_stall=1 whenever the hazard is present.
- Accept condition: o_in_ready = !hazard & (!o_valid | i_out_ready). Capture on i_valid & o_in_ready.
- Latency: 1 cycle from accept to o_valid.
- Output register:
  - Holds o_* stable while o_valid & !i_out_ready.
  - On i_out_ready with no accept, o_valid->0 (bubble).
  - Simultaneous drain and accept gives back-to-back issue with no gap.
- Stall while full: the stall is evaluated every cycle regardless of downstream state; the held output is unaffected.
- Reset mid-stall or mid-hold: the pending instruction is discarded and all outputs return to reset values next edge.

Optional Feature:
ALU_OPSTAGE_STATS_EN.
- Defined: adds outputs o_stall_cnt[15:0] and o_fwd_cnt[15:0].
  - o_stall_cnt increments each cycle o_stall=1.
  - o_fwd_cnt increments per accepted instruction using any forwarded source (+1 max per instruction).
  - Both saturate at 16'hFFFF and clear on reset.
- Undefined: ports and counters absent; the rest of the behaviour is identical.

Decomposition:
- Shared package alu_pkg:
  - LHS_RS/LHS_RT constants.
  - RHS_RS=2'b00, RHS_RT=2'b01, RHS_SHAMT=2'b10, RHS_IMM=2'b11.
  - State encoding ST_RUN/ST_STALL.
- One sub-module fwd_mux: a single-source forward selector, instantiated twice (rs, rt).

Test Plan:
- Reset: assert reset 2 cycles mid-hold -> o_valid=0, o_rhs_ctrl=01, o_lhs=o_rhs=0.
- ADDI, imm=16'hFFFC, signed, rs=3 (rf=10) -> next cycle o_lhs=10, o_rhs=32'hFFFFFFFC, ctrl 0/11. Same with unsigned -> o_rhs=32'h0000FFFC.
- SLL, shamt=7, rt=4; EX writes r4=0x55 and MEM writes r4=0x11 -> o_lhs=0x55 (EX priority), o_rhs=7, ctrl 1/10.
- Load-use: EX load to r5; ADD rs=5 -> o_stall=1, o_in_ready=0 for 1 cycle. Next cycle MEM r5=0x99 -> o_lhs=0x99.
- Forward to r0: EX writes r0=0xDEAD; ADD rs=0 with rf=0 -> o_lhs=0, no stall.
- Backpressure: i_out_ready=0 for 3 cycles with i_valid high -> output stable, o_in_ready=0. On release, back-to-back issue with no bubble.
